// File: rtl/max_pool_engine.sv
// 2x2 stride-2 signed max-pool engine: streams a MAP_W x MAP_W map out of the
// convolution result buffer and writes the pooled (MAP_W/2)^2 map.
module max_pool_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAP_W  = 6,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              max_pool_done
);

  localparam int unsigned HALF  = MAP_W / 2;
  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(HALF - 1);
  localparam logic [ADDR_W-1:0] ROW1 = ADDR_W'(MAP_W);
  localparam logic [ADDR_W-1:0] ROW2 = ADDR_W'(2 * MAP_W);
  localparam logic [ADDR_W-1:0] OUT_ROW = ADDR_W'(HALF);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, WR, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         r_q, r_d, c_q, c_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic signed [DATA_W-1:0] rd_data_s, cand;
  logic [ADDR_W-1:0]        base_d, rd_addr_d, wr_addr_d;
  logic                     rd_en_d, wr_en_d, busy_d, done_d;

  assign rd_data_s = $signed(rd_data);
  assign cand      = (rd_data_s > max_q) ? rd_data_s : max_q;

  // The last element of a window lands in the WR cycle, so the pooled value is combinational.
  assign wr_data = wr_en ? cand : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      r_q           <= '0;
      c_q           <= '0;
      max_q         <= '0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      busy          <= 1'b0;
      max_pool_done <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      c_q           <= c_d;
      max_q         <= max_d;
      rd_en         <= rd_en_d;
      rd_addr       <= rd_addr_d;
      wr_en         <= wr_en_d;
      wr_addr       <= wr_addr_d;
      busy          <= busy_d;
      max_pool_done <= done_d;
    end
  end

  // Next state, window counters and running max.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    max_d   = max_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD0;
          r_d     = '0;
          c_d     = '0;
        end
      end
      RD0: state_d = RD1;
      RD1: begin
        state_d = RD2;
        max_d   = rd_data_s;
      end
      RD2: begin
        state_d = RD3;
        max_d   = cand;
      end
      RD3: begin
        state_d = WR;
        max_d   = cand;
      end
      WR: begin
        max_d = cand;
        if (c_q == LAST) begin
          c_d = '0;
          if (r_q == LAST) begin
            r_d     = '0;
            state_d = DONE;
          end else begin
            r_d     = r_q + CNT_W'(1);
            state_d = RD0;
          end
        end else begin
          c_d     = c_q + CNT_W'(1);
          state_d = RD0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the upcoming state, registered at the edge that enters it.
  always_comb begin
    base_d    = ADDR_W'(r_d) * ROW2 + ADDR_W'({c_d, 1'b0});
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    case (state_d)
      RD0: begin
        rd_en_d   = 1'b1;
        rd_addr_d = base_d;
      end
      RD1: begin
        rd_en_d   = 1'b1;
        rd_addr_d = base_d + ADDR_W'(1);
      end
      RD2: begin
        rd_en_d   = 1'b1;
        rd_addr_d = base_d + ROW1;
      end
      RD3: begin
        rd_en_d   = 1'b1;
        rd_addr_d = base_d + ROW1 + ADDR_W'(1);
      end
      WR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_W'(r_d) * OUT_ROW + ADDR_W'(c_d);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_max_pool_engine.sv
// Bench for max_pool_engine: buffer model, window-max reference, write scoreboard
// and protocol monitor.
module tb_max_pool_engine;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MAP_W    = 6;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned HALF     = MAP_W / 2;
  localparam int unsigned NWIN     = HALF * HALF;
  localparam int          PASS_CYC = 5 * NWIN + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              max_pool_done;

  logic [DATA_W-1:0] mem [0:63];
  wr_t               exp_q[$];
  int                vectors = 0;
  int                miscompares = 0;
  int                cyc = 0;
  int                done_pending = 0;
  logic              prev_wr_en = 1'b0;
  logic              prev_done = 1'b0;

  max_pool_engine #(.DATA_W(DATA_W), .MAP_W(MAP_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .max_pool_done(max_pool_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Result buffer: one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and protocol monitor.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (rd_en || wr_en) check("rd_wr_exclusive", 32'(rd_en & wr_en), 0);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: addr %0d data %0h, expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
      if (max_pool_done) begin
        check("done_after_last_write", 32'(prev_wr_en), 1);
        check("done_writes_drained", 32'(exp_q.size()), 0);
        check("done_one_cycle", 32'(prev_done), 0);
        if (done_pending == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got pulse, expected none (cycle %0d)", cyc);
        end else begin
          done_pending--;
        end
      end
    end
    prev_wr_en = wr_en;
    prev_done  = max_pool_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: each output is the signed maximum of its 2x2 input window.
  task automatic push_expected(input int nwin);
    for (int w = 0; w < nwin; w++) begin
      int  r;
      int  c;
      int  best;
      wr_t e;
      r    = w / HALF;
      c    = w % HALF;
      best = -1000;
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++) begin
          int v;
          v = int'($signed(mem[(2 * r + dy) * MAP_W + 2 * c + dx]));
          if (v > best) best = v;
        end
      e.addr = ADDR_W'(w);
      e.data = DATA_W'(best);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int limit, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (max_pool_done) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected one", limit);
    end
  endtask

  task automatic run_pass(input string name);
    int k;
    int d;
    push_expected(NWIN);
    done_pending++;
    start = 1'b1;
    k = cyc + 1;
    tick();
    start = 1'b0;
    wait_done(PASS_CYC + 20, d);
    if (d >= 0) check({name, "_done_cycle"}, 32'(d + 1 - k), 32'(PASS_CYC));
    tick();
  endtask

  task automatic fill_random(input bit narrow);
    logic [DATA_W-1:0] pick [0:3];
    pick[0] = 8'h80; pick[1] = 8'h7F; pick[2] = 8'hFF; pick[3] = 8'h00;
    for (int i = 0; i < 64; i++)
      mem[i] = narrow ? pick[$urandom_range(0, 3)] : DATA_W'($urandom_range(0, 255));
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_rd_en"}, 32'(rd_en), 0);
    check({name, "_wr_en"}, 32'(wr_en), 0);
    check({name, "_done"}, 32'(max_pool_done), 0);
    check({name, "_rd_addr"}, 32'(rd_addr), 0);
    check({name, "_wr_addr"}, 32'(wr_addr), 0);
    check({name, "_wr_data"}, 32'(wr_data), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = DATA_W'(i);
    repeat (3) tick();
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_wr_data_known", 32'($isunknown(wr_data)), 0);
    tick();
    rst = 1'b0;
    tick();

    // Ramp 0..35: pooled values 7,9,11,19,21,23,31,33,35 at addresses 0..8.
    run_pass("ramp");

    for (int i = 0; i < 64; i++) mem[i] = 8'h80;
    run_pass("all_min");
    mem[14] = 8'h7F;
    run_pass("single_max");

    fill_random(1'b0);
    mem[0] = 8'hFB; mem[1] = 8'hFD; mem[6] = 8'hF7; mem[7] = 8'hFD;
    run_pass("neg_tie");

    for (int p = 0; p < 6; p++) begin
      fill_random(p[0]);
      run_pass("random");
    end

    // Reset during RD2 of the third window (output 2, base address 4).
    fill_random(1'b0);
    push_expected(2);
    start = 1'b1;
    k = cyc + 1;
    tick();
    start = 1'b0;
    while (cyc < k + 12) tick();
    @(negedge clk);
    check("abort_rd2_en", 32'(rd_en), 1);
    check("abort_rd2_addr", 32'(rd_addr), 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    check("abort_writes_drained", 32'(exp_q.size()), 0);
    repeat (20) tick();
    check("abort_stays_idle", 32'(busy), 0);
    run_pass("after_abort");

    // Start re-pulsed mid-pass, then held through DONE to chain a second pass.
    fill_random(1'b0);
    push_expected(NWIN);
    done_pending++;
    start = 1'b1;
    k = cyc + 1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1;
    wait_done(PASS_CYC + 20, d);
    if (d >= 0) check("hold_first_done_cycle", 32'(d + 1 - k), 32'(PASS_CYC));
    tick();
    @(negedge clk);
    check("hold_idle_busy", 32'(busy), 0);
    push_expected(NWIN);
    done_pending++;
    tick();
    @(negedge clk);
    check("hold_rd0_en", 32'(rd_en), 1);
    check("hold_rd0_addr", 32'(rd_addr), 0);
    k = cyc;
    start = 1'b0;
    wait_done(PASS_CYC + 20, d);
    if (d >= 0) check("hold_second_done_cycle", 32'(d + 1 - k), 32'(PASS_CYC));
    tick();
    repeat (5) tick();
    check("final_queue_empty", 32'(exp_q.size()), 0);
    check("final_done_pending", 32'(done_pending), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/max_pool_engine.md
MAX_POOL_ENGINE -- requirements
Module: max_pool_engine

Interface
REQ-001 Parameter DATA_W, default 8: signed feature-map element width (two's complement).
REQ-002 Parameter MAP_W, default 6: input map width and height in elements; even, >= 2.
REQ-003 Parameter ADDR_W, default 6: address width; holds MAP_W*MAP_W-1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  level; sampled only in IDLE; launches one full pooling pass.
REQ-007 rd_en  output  1  read strobe to the convolution result buffer.
REQ-008 rd_addr  output  ADDR_W  read address, row-major, element (y,x) at y*MAP_W+x.
REQ-009 rd_data  input  DATA_W  buffer read data, valid exactly one cycle after rd_en.
REQ-010 wr_en  output  1  write strobe to the pooled-output buffer.
REQ-011 wr_addr  output  ADDR_W  write address, row-major over a (MAP_W/2)x(MAP_W/2) map.
REQ-012 wr_data  output  DATA_W  pooled element.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 max_pool_done  output  1  one-cycle pulse at end of pass; drives the top-level controller's Max_Pool exit.

Function
REQ-015 Operation: 2x2 window, stride 2, signed maximum; output element (r,c) = max of inputs (2r,2c),(2r,2c+1),(2r+1,2c),(2r+1,2c+1).
REQ-016 States: IDLE, RD0, RD1, RD2, RD3, WR, DONE.
REQ-017 IDLE -> RD0 when start=1; otherwise stay in IDLE.
REQ-018 RD0..RD3 assert rd_en with rd_addr = base, base+1, base+MAP_W, base+MAP_W+1, where base = 2r*MAP_W + 2c.
REQ-019 Running max register: loaded with rd_data in RD1; in RD2, RD3, WR updated to signed max(reg, rd_data).
REQ-020 WR: wr_en=1, wr_addr = r*(MAP_W/2)+c, wr_data = signed max(reg, rd_data) (combinational including the RD3 data).
REQ-021 WR -> RD0 of next window (c increments; at c=MAP_W/2-1, c wraps to 0 and r increments); after window (MAP_W/2-1, MAP_W/2-1) WR -> DONE.
REQ-022 DONE: max_pool_done=1 for exactly that cycle; DONE -> IDLE unconditionally.
REQ-023 Timing: start sampled at edge k gives RD0 in cycle k+1; each window takes 5 cycles; the last wr_en falls in cycle k+5*(MAP_W/2)^2; max_pool_done in the next cycle (k+46 for MAP_W=6).
REQ-024 Ties: equal values give that value; comparison is signed, so 8'h80 (-128) never beats any other value.
REQ-025 start while busy is ignored; start high in the DONE cycle is ignored; start held high in IDLE after DONE launches a new pass.
REQ-026 rd_en, wr_en and max_pool_done are never high in the same cycle, except that rd_en and wr_en are mutually exclusive by state.
REQ-027 When rd_en=0, rd_addr holds its last value. When wr_en=0, wr_addr and wr_data are don't-care but must not be X after reset.

Reset
REQ-028 rst=1 at an edge forces IDLE; r, c and the max register clear to 0; rd_en, wr_en, busy and max_pool_done are 0; rd_addr, wr_addr and wr_data are 0.
REQ-029 Reset mid-pass aborts immediately: no further reads or writes, and no max_pool_done for the aborted pass.
REQ-030 rst has priority over start in the same cycle.

Verification
REQ-031 MAP_W=6, input element i = i (0..35), start pulse -> 9 writes of 7,9,11,19,21,23,31,33,35 to addresses 0..8; done at cycle k+46.
REQ-032 All 36 elements = 8'h80 -> every wr_data = 8'h80. Separately, a single 8'h7F at element 14 -> output addr 4 = 8'h7F, all other outputs = 8'h80.
REQ-033 Window 0 = {-5, -3, -9, -3} -> wr_data = -3 (8'hFD) at address 0; checks the signed path and the tie path.
REQ-034 rst asserted during the 3rd window's RD2 -> next cycle is IDLE with all outputs 0; no done pulse; a later start produces a full 9-write pass.
REQ-035 start re-pulsed during busy and held high through DONE -> the first pass is unaffected; the second pass's RD0 begins the cycle after IDLE is entered.
REQ-036 Protocol checker throughout: rd_en and wr_en never both high; max_pool_done is exactly one cycle and only after the final write.
